step_ctrl: RTL and testbench
============================

# step_ctrl

Consumer of the divided clock: samples the slow `clk_div` toggle in the fast `clk` domain and turns it into single-cycle processor clock-enable pulses. Supports free-run, single-step and halt, so the DRAM/IRAM datapath advances one step per accepted divider edge. Sits between the clock divider and the processor core enable, and counts the steps it has issued.

## Interface
- `SYNC_STAGES`, default 2, synchronizer depth for `clk_div` and `step`; legal range ≥ 2.
- `CNT_W`, default 16, width of the issued-step counter.

- `clk`  in  1  system clock; all flops on rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `clk_div`  in  1  slow toggle from the clock divider; treated as asynchronous.
- `run`  in  1  level, synchronous; 1 = free-run, 0 = stop after current state.
- `step`  in  1  level from a pushbutton, asynchronous; a rising edge requests one step.
- `halt`  in  1  synchronous, from the processor; 1 = stop permanently.
- `cpu_en`  out  1  registered one-`clk` pulse per issued step.
- `ticks`  out  CNT_W  number of pulses issued since reset, modulo 2^CNT_W.
- `state`  out  2  current FSM state encoding.
- `halted`  out  1  1 while in HALTED.

## Operation
- `clk_div` and `step` each pass through a `SYNC_STAGES` flop chain. Each chain is followed by a prev-flop. `div_rise` = sync & ~prev and `step_rise` = sync & ~prev, both combinational and one cycle wide.
- FSM states: IDLE = 00, RUN = 01, ARMED = 10, HALTED = 11.
- IDLE transitions, in priority order:
  - `halt` → HALTED.
  - else `run` → RUN.
  - else `step_rise` → ARMED.
  - else stay.
- RUN transitions, in priority order:
  - `halt` → HALTED, no pulse.
  - else `!run` → IDLE, no pulse, even if `div_rise` is high that cycle.
  - else on `div_rise`: pulse and stay.
- ARMED transitions, in priority order:
  - `halt` → HALTED, no pulse.
  - else on `div_rise`: pulse and → IDLE.
  - else stay. `run` and `step_rise` are ignored in ARMED.
- HALTED: terminal. Only reset leaves it. `cpu_en` stays 0 and `ticks` is frozen.
- `step_rise` outside IDLE is discarded, not queued.
- Pulse: `cpu_en` is registered high for exactly one cycle. `ticks` increments on the same edge and wraps from 2^CNT_W−1 to 0.
- Falling edges of `clk_div` are ignored. One pulse is issued per `clk_div` rising edge, i.e. one per two divider toggles.
- `halted` = (state == HALTED).

## Timing
- Reset (`rst` = 0, asynchronous) forces:
  - state IDLE;
  - `cpu_en` 0, `ticks` 0, `halted` 0;
  - all synchronizer and prev flops 0.
- Reset asserted mid-operation takes effect immediately: any pending ARMED step is lost and a pulse in progress is cut short.
- `clk_div` latency: a rise meeting setup before clk edge 1 reaches the last sync flop at edge `SYNC_STAGES`. `cpu_en` is then high in the cycle after edge `SYNC_STAGES`+1 (edge 3 for the default). `step` follows the same latency into `step_rise`.
- If `clk_div` is already 1 when reset releases, the synchronizer sees a rise and `div_rise` fires once after `SYNC_STAGES` cycles. It produces a pulse only if the FSM is in RUN or ARMED by then.
- State changes take effect on the edge after the decision cycle. `state` and `halted` are registered outputs.
- Minimum `clk_div` high and low time is `SYNC_STAGES`+1 `clk` cycles. Shorter pulses may be missed; this is by design and not an error.

## Test plan
- Reset, then `run` = 1 and `clk_div` toggled with period 20 `clk` (10 high / 10 low) for 5 rises:
  - exactly 5 single-cycle `cpu_en` pulses, each 3 cycles after its rise;
  - `ticks` = 5, `state` = 01.
- `run` = 0, one `step` rise, then 3 `clk_div` rises:
  - `state` goes 00 → 10 → 00;
  - exactly 1 pulse, on the first rise only;
  - `ticks` +1.
- Assert `halt` for 1 cycle in the same cycle as `div_rise`, while in RUN:
  - no pulse, `state` = 11, `halted` = 1;
  - further `run`, `step` and `clk_div` activity gives no pulses and no `ticks` change.
- `CNT_W` = 4, RUN, 17 rises:
  - `ticks` sequence ends ..., 15, 0, 1;
  - 17 pulses total.
- Drop `run` in the same cycle as `div_rise`:
  - no pulse, `state` = 00.
- A second `step` rise while ARMED:
  - still only 1 pulse.
- Assert `rst` low asynchronously while ARMED:
  - all outputs go to 0 immediately;
  - after release, the next `clk_div` rise gives no pulse.

Source files
------------

// File: rtl/step_ctrl.sv
// step_ctrl: turns rising edges of the divided clock into single-cycle
// processor clock-enable pulses, with free-run, single-step and halt modes.
module step_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_div,
    input  logic             run,
    input  logic             step,
    input  logic             halt,
    output logic             cpu_en,
    output logic [CNT_W-1:0] ticks,
    output logic [1:0]       state,
    output logic             halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        ARMED  = 2'b10,
        HALTED = 2'b11
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] div_sync;
    logic [SYNC_STAGES-1:0] step_sync;
    logic                   div_prev;
    logic                   step_prev;
    logic                   div_rise_c;
    logic                   step_rise_c;

    // Synchronize the asynchronous divider toggle and pushbutton, keep one
    // extra flop of history for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_sync  <= '0;
            step_sync <= '0;
            div_prev  <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            div_sync  <= {div_sync[SYNC_STAGES-2:0], clk_div};
            step_sync <= {step_sync[SYNC_STAGES-2:0], step};
            div_prev  <= div_sync[SYNC_STAGES-1];
            step_prev <= step_sync[SYNC_STAGES-1];
        end
    end

    // Rising-edge strobes; falling edges of either input are ignored
    assign div_rise_c  = div_sync[SYNC_STAGES-1] & ~div_prev;
    assign step_rise_c = step_sync[SYNC_STAGES-1] & ~step_prev;

    // Mode FSM with registered enable pulse, step counter and halted flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cpu_en  <= 1'b0;
            ticks   <= '0;
            halted  <= 1'b0;
        end else begin
            cpu_en <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (halt) begin
                        state_q <= HALTED;
                        halted  <= 1'b1;
                    end else if (run) begin
                        state_q <= RUN;
                    end else if (step_rise_c) begin
                        state_q <= ARMED;
                    end
                end
                RUN: begin
                    if (halt) begin
                        state_q <= HALTED;
                        halted  <= 1'b1;
                    end else if (!run) begin
                        state_q <= IDLE;
                    end else if (div_rise_c) begin
                        cpu_en <= 1'b1;
                        ticks  <= ticks + CNT_W'(1);
                    end
                end
                ARMED: begin
                    // run and further step requests are deliberately ignored here
                    if (halt) begin
                        state_q <= HALTED;
                        halted  <= 1'b1;
                    end else if (div_rise_c) begin
                        cpu_en  <= 1'b1;
                        ticks   <= ticks + CNT_W'(1);
                        state_q <= IDLE;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                    halted  <= 1'b1;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_step_ctrl.sv
// Scoreboard bench for step_ctrl: stimulus pushes expected pulses (cycle and
// ticks value), monitors pop and compare whenever cpu_en is seen high.
module tb_step_ctrl;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_ARMED  = 2'b10;
    localparam logic [1:0] S_HALTED = 2'b11;

    typedef struct {
        int          cyc;
        logic [31:0] tk;
    } pulse_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_div;
    logic        run;
    logic        step;
    logic        halt;
    logic        cpu_en;
    logic [15:0] ticks;
    logic [1:0]  state;
    logic        halted;

    logic        run4;
    logic        step4;
    logic        halt4;
    logic        cpu_en4;
    logic [3:0]  ticks4;
    logic [1:0]  state4;
    logic        halted4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulses   = 0;
    int pulses4  = 0;
    int exp_ticks  = 0;
    int exp_ticks4 = 0;

    pulse_t q[$];
    pulse_t q4[$];
    pulse_t e_main;
    pulse_t e_4;

    step_ctrl #(.SYNC_STAGES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .clk_div(clk_div), .run(run), .step(step),
        .halt(halt), .cpu_en(cpu_en), .ticks(ticks), .state(state), .halted(halted)
    );

    step_ctrl #(.SYNC_STAGES(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .clk_div(clk_div), .run(run4), .step(step4),
        .halt(halt4), .cpu_en(cpu_en4), .ticks(ticks4), .state(state4), .halted(halted4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor for the 16-bit instance
    always @(negedge clk) begin
        if (cpu_en === 1'b1) begin
            pulses++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pulse_unexpected: got pulse at cycle %0d ticks %0d, required none", cyc, ticks);
            end else begin
                e_main = q.pop_front();
                chk("pulse_cycle", 32'(cyc), 32'(e_main.cyc));
                chk("pulse_ticks", 32'(ticks), e_main.tk);
            end
        end
    end

    // Monitor for the 4-bit counter instance
    always @(negedge clk) begin
        if (cpu_en4 === 1'b1) begin
            pulses4++;
            if (q4.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pulse4_unexpected: got pulse at cycle %0d ticks %0d, required none", cyc, ticks4);
            end else begin
                e_4 = q4.pop_front();
                chk("pulse4_cycle", 32'(cyc), 32'(e_4.cyc));
                chk("pulse4_ticks", 32'(ticks4), e_4.tk);
            end
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One divider period: 10 cycles high, 10 low; pulse lands 3 cycles after the rise
    task automatic div_cycle(input bit exp_main, input bit exp4);
        pulse_t p;
        @(negedge clk);
        clk_div = 1'b1;
        if (exp_main) begin
            exp_ticks = (exp_ticks + 1) % 65536;
            p.cyc = cyc + 3;
            p.tk  = 32'(exp_ticks);
            q.push_back(p);
        end
        if (exp4) begin
            exp_ticks4 = (exp_ticks4 + 1) % 16;
            p.cyc = cyc + 3;
            p.tk  = 32'(exp_ticks4);
            q4.push_back(p);
        end
        wait_neg(10);
        clk_div = 1'b0;
        wait_neg(10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; clk_div = 1'b0; run = 1'b0; step = 1'b0; halt = 1'b0;
        run4 = 1'b0; step4 = 1'b0; halt4 = 1'b0;
        wait_neg(3);
        chk("reset_state", 32'(state), 32'(S_IDLE));
        chk("reset_cpu_en", 32'(cpu_en), 0);
        chk("reset_ticks", 32'(ticks), 0);
        chk("reset_halted", 32'(halted), 0);
        rst = 1'b1;
        wait_neg(3);

        // Free-run: five divider rises, five pulses
        run = 1'b1;
        wait_neg(2);
        chk("run_state", 32'(state), 32'(S_RUN));
        for (int i = 0; i < 5; i++) div_cycle(1'b1, 1'b0);
        chk("run_ticks", 32'(ticks), 5);
        chk("run_pulses", 32'(pulses), 5);
        chk("run_state_after", 32'(state), 32'(S_RUN));

        // Single step, with a second step request while armed
        run = 1'b0;
        wait_neg(2);
        chk("stop_state", 32'(state), 32'(S_IDLE));
        step = 1'b1;
        wait_neg(4);
        chk("armed_state", 32'(state), 32'(S_ARMED));
        step = 1'b0;
        wait_neg(4);
        step = 1'b1;
        wait_neg(4);
        chk("armed_second_step", 32'(state), 32'(S_ARMED));
        step = 1'b0;
        div_cycle(1'b1, 1'b0);
        chk("step_back_idle", 32'(state), 32'(S_IDLE));
        div_cycle(1'b0, 1'b0);
        div_cycle(1'b0, 1'b0);
        chk("step_ticks", 32'(ticks), 6);
        chk("step_pulses", 32'(pulses), 6);

        // Drop run in the same cycle div_rise is seen
        run = 1'b1;
        wait_neg(3);
        clk_div = 1'b1;
        wait_neg(2);
        run = 1'b0;
        wait_neg(2);
        chk("droprun_state", 32'(state), 32'(S_IDLE));
        wait_neg(8);
        clk_div = 1'b0;
        wait_neg(10);
        chk("droprun_ticks", 32'(ticks), 6);

        // Halt coincident with div_rise while running
        run = 1'b1;
        wait_neg(3);
        clk_div = 1'b1;
        wait_neg(2);
        halt = 1'b1;
        wait_neg(1);
        halt = 1'b0;
        wait_neg(1);
        chk("halt_state", 32'(state), 32'(S_HALTED));
        chk("halt_flag", 32'(halted), 1);
        wait_neg(8);
        clk_div = 1'b0;
        wait_neg(10);
        run = 1'b0;
        wait_neg(3);
        run = 1'b1;
        step = 1'b1;
        wait_neg(5);
        step = 1'b0;
        wait_neg(5);
        div_cycle(1'b0, 1'b0);
        div_cycle(1'b0, 1'b0);
        chk("halted_ticks", 32'(ticks), 6);
        chk("halted_state", 32'(state), 32'(S_HALTED));
        chk("halted_flag_held", 32'(halted), 1);

        // 4-bit counter wraps through 15, 0, 1
        run4 = 1'b1;
        wait_neg(3);
        for (int i = 0; i < 17; i++) div_cycle(1'b0, 1'b1);
        chk("wrap_ticks", 32'(ticks4), 1);
        chk("wrap_pulses", 32'(pulses4), 17);
        chk("wrap_main_ticks", 32'(ticks), 6);

        // Reset out of HALTED, then arm and reset asynchronously
        rst = 1'b0; run = 1'b0; run4 = 1'b0; step = 1'b0;
        wait_neg(2);
        exp_ticks = 0;
        exp_ticks4 = 0;
        chk("rst_halt_state", 32'(state), 32'(S_IDLE));
        chk("rst_halt_flag", 32'(halted), 0);
        rst = 1'b1;
        wait_neg(4);
        step = 1'b1;
        wait_neg(4);
        chk("rearm_state", 32'(state), 32'(S_ARMED));
        div_cycle(1'b1, 1'b0);
        chk("rearm_ticks", 32'(ticks), 1);
        step = 1'b0;
        wait_neg(4);
        step = 1'b1;
        wait_neg(4);
        chk("armed_before_rst", 32'(state), 32'(S_ARMED));
        #2;
        rst = 1'b0;
        step = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'(S_IDLE));
        chk("async_rst_ticks", 32'(ticks), 0);
        chk("async_rst_cpu_en", 32'(cpu_en), 0);
        chk("async_rst_halted", 32'(halted), 0);
        chk("async_rst_ticks4", 32'(ticks4), 0);
        exp_ticks = 0;
        wait_neg(2);
        rst = 1'b1;
        wait_neg(4);
        div_cycle(1'b0, 1'b0);
        chk("post_rst_ticks", 32'(ticks), 0);
        chk("post_rst_state", 32'(state), 32'(S_IDLE));

        wait_neg(5);
        chk("queue_empty", 32'(q.size()), 0);
        chk("queue4_empty", 32'(q4.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
